// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with thresholds, occupancy count,
// overflow/underflow pulses and selectable registered or FWFT read.
//
// Ports:
//   clk          single clock, rising edge
//   rst          asynchronous reset, active-low
//   data_in      write data
//   write_en     write request
//   read_en      read request
//   data_out     read data (registered, or head word when FWFT)
//   data_valid   new word on data_out (FWFT=0) / ~empty (FWFT=1)
//   full         count == DEPTH
//   empty        count == 0
//   almost_full  count >= AF_THRESH
//   almost_empty count <= AE_THRESH
//   count        occupancy, 0..DEPTH
//   overflow     one-cycle pulse: write rejected
//   underflow    one-cycle pulse: read rejected
module sync_fifo_param #(
    parameter int DEPTH     = 32,
    parameter int WIDTH     = 8,
    parameter int AF_THRESH = DEPTH - 4,
    parameter int AE_THRESH = 4,
    parameter int FWFT      = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         data_in,
    input  logic                     write_en,
    input  logic                     read_en,
    output logic [WIDTH-1:0]         data_out,
    output logic                     data_valid,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

    // Flag values for an empty FIFO, derived so odd thresholds stay consistent
    localparam logic AF_RST = (AF_THRESH == 0);
    localparam logic AE_RST = 1'b1;

    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("sync_fifo_param: DEPTH must be a power of 2 and >= 4");
    end

    if (AF_THRESH < 0 || AF_THRESH > DEPTH ||
        AE_THRESH < 0 || AE_THRESH > DEPTH) begin : g_bad_thresh
        $error("sync_fifo_param: thresholds must lie within 0..DEPTH");
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_next;
    logic             full_q;
    logic             empty_q;
    logic             af_q;
    logic             ae_q;
    logic             ovf_q;
    logic             unf_q;
    logic             wr_acc;
    logic             rd_acc;

    // A write into a full FIFO is allowed only when a read frees a slot
    // in the same cycle; a read of an empty FIFO is never allowed.
    always_comb begin
        rd_acc     = read_en & ~empty_q;
        wr_acc     = write_en & (~full_q | rd_acc);
        count_next = count_q + CW'(wr_acc) - CW'(rd_acc);
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            af_q    <= AF_RST;
            ae_q    <= AE_RST;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count_q <= count_next;
            full_q  <= (count_next == DEPTH_C);
            empty_q <= (count_next == '0);
            af_q    <= (count_next >= AF_C);
            ae_q    <= (count_next <= AE_C);
            ovf_q   <= write_en & ~wr_acc;
            unf_q   <= read_en & ~rd_acc;
        end
    end

    if (FWFT != 0) begin : g_fwft
        // Head word shown directly; empty is registered, so a word written
        // into an empty FIFO appears the cycle after its write edge.
        assign data_out   = empty_q ? '0 : mem[rd_ptr];
        assign data_valid = ~empty_q;
    end else begin : g_reg
        logic [WIDTH-1:0] dout_q;
        logic             dv_q;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                dout_q <= '0;
                dv_q   <= 1'b0;
            end else begin
                dv_q <= rd_acc;
                if (rd_acc) begin
                    dout_q <= mem[rd_ptr];
                end
            end
        end

        assign data_out   = dout_q;
        assign data_valid = dv_q;
    end

    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Testbench for sync_fifo_param: registered-read and FWFT instances
// checked against a queue-based reference model.
module tb_sync_fifo_param;

    localparam int D  = 32;
    localparam int W  = 8;
    localparam int CW = 6;
    localparam int SW = CW + 7 + W;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [W-1:0]  din0, din1;
    logic          we0, re0, we1, re1;
    logic [W-1:0]  dout0, dout1;
    logic          dv0, dv1, full0, full1, empty0, empty1;
    logic          af0, af1, ae0, ae1, ovf0, ovf1, unf0, unf1;
    logic [CW-1:0] cnt0, cnt1;

    sync_fifo_param #(.DEPTH(D), .WIDTH(W), .FWFT(0)) u0 (
        .clk(clk), .rst(rst), .data_in(din0),
        .write_en(we0), .read_en(re0),
        .data_out(dout0), .data_valid(dv0),
        .full(full0), .empty(empty0),
        .almost_full(af0), .almost_empty(ae0),
        .count(cnt0), .overflow(ovf0), .underflow(unf0)
    );

    sync_fifo_param #(.DEPTH(D), .WIDTH(W), .FWFT(1)) u1 (
        .clk(clk), .rst(rst), .data_in(din1),
        .write_en(we1), .read_en(re1),
        .data_out(dout1), .data_valid(dv1),
        .full(full1), .empty(empty1),
        .almost_full(af1), .almost_empty(ae1),
        .count(cnt1), .overflow(ovf1), .underflow(unf1)
    );

    int n_chk;
    int n_fail;

    logic [W-1:0] q0[$];
    logic [W-1:0] q1[$];
    logic [W-1:0] e_dout0;
    logic         e_dv0, e_ovf0, e_unf0, e_ovf1, e_unf1;

    function automatic logic [SW-1:0] got0();
        return {cnt0, full0, empty0, af0, ae0, ovf0, unf0, dv0, dout0};
    endfunction

    function automatic logic [SW-1:0] exp0();
        int n = q0.size();
        return {CW'(n), n == D, n == 0, n >= D - 4, n <= 4,
                e_ovf0, e_unf0, e_dv0, e_dout0};
    endfunction

    function automatic logic [SW-1:0] got1();
        return {cnt1, full1, empty1, af1, ae1, ovf1, unf1, dv1, dout1};
    endfunction

    function automatic logic [SW-1:0] exp1();
        int n = q1.size();
        logic [W-1:0] h = (n != 0) ? q1[0] : '0;
        return {CW'(n), n == D, n == 0, n >= D - 4, n <= 4,
                e_ovf1, e_unf1, n != 0, h};
    endfunction

    task automatic model_reset();
        q0.delete();
        q1.delete();
        e_dout0 = '0;
        e_dv0   = 1'b0;
        e_ovf0  = 1'b0;
        e_unf0  = 1'b0;
        e_ovf1  = 1'b0;
        e_unf1  = 1'b0;
    endtask

    // One clock of the registered-read instance plus the model update.
    task automatic step0(input logic we, input logic re,
                         input logic [W-1:0] d);
        bit ra, wa;
        we0  = we;
        re0  = re;
        din0 = d;
        ra = re && (q0.size() != 0);
        wa = we && ((q0.size() < D) || ra);
        @(posedge clk);
        #1;
        e_ovf0 = we && !wa;
        e_unf0 = re && !ra;
        e_dv0  = ra;
        if (ra) e_dout0 = q0.pop_front();
        if (wa) q0.push_back(d);
        we0 = 1'b0;
        re0 = 1'b0;
    endtask

    task automatic step1(input logic we, input logic re,
                         input logic [W-1:0] d);
        bit ra, wa;
        we1  = we;
        re1  = re;
        din1 = d;
        ra = re && (q1.size() != 0);
        wa = we && ((q1.size() < D) || ra);
        @(posedge clk);
        #1;
        e_ovf1 = we && !wa;
        e_unf1 = re && !ra;
        if (ra) void'(q1.pop_front());
        if (wa) q1.push_back(d);
        we1 = 1'b0;
        re1 = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        model_reset();
        n_chk++;
        if (got0() !== exp0()) begin
            n_fail++;
            $display("FAIL reset_hold0 got %h exp %h", got0(), exp0());
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_chk++;
        if ({cnt0, empty0, ae0, full0, af0, dout0, dv0, ovf0, unf0}
            !== {6'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_idle0 got cnt=%0d e=%b ae=%b f=%b af=%b do=%h dv=%b o=%b u=%b",
                     cnt0, empty0, ae0, full0, af0, dout0, dv0, ovf0, unf0);
        end
        n_chk++;
        if (got1() !== exp1()) begin
            n_fail++;
            $display("FAIL reset_idle1 got %h exp %h", got1(), exp1());
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < D; i++) begin
            step0(1'b1, 1'b0, W'(i));
            n_chk++;
            if (got0() !== exp0()) begin
                n_fail++;
                $display("FAIL fill_%0d got %h exp %h", i, got0(), exp0());
            end
            if (i == 3 || i == 4) begin
                n_chk++;
                if (ae0 !== (i == 3)) begin
                    n_fail++;
                    $display("FAIL fill_ae_%0d got %b exp %b", i, ae0, i == 3);
                end
            end
            if (i == 26 || i == 27) begin
                n_chk++;
                if (af0 !== (i == 27)) begin
                    n_fail++;
                    $display("FAIL fill_af_%0d got %b exp %b", i, af0, i == 27);
                end
            end
        end
        n_chk++;
        if ({full0, cnt0} !== {1'b1, 6'd32}) begin
            n_fail++;
            $display("FAIL fill_full got full=%b cnt=%0d exp 1/32", full0, cnt0);
        end
        step0(1'b1, 1'b0, 8'hAA);
        n_chk++;
        if ({ovf0, cnt0} !== {1'b1, 6'd32}) begin
            n_fail++;
            $display("FAIL fill_ovf got ovf=%b cnt=%0d exp 1/32", ovf0, cnt0);
        end
        step0(1'b0, 1'b0, 8'h00);
        n_chk++;
        if (ovf0 !== 1'b0 || got0() !== exp0()) begin
            n_fail++;
            $display("FAIL fill_ovf_end got %h exp %h", got0(), exp0());
        end
    endtask

    task automatic test_drain();
        for (int i = 0; i < D; i++) begin
            step0(1'b0, 1'b1, 8'h00);
            n_chk++;
            if ({dv0, dout0} !== {1'b1, W'(i)} || got0() !== exp0()) begin
                n_fail++;
                $display("FAIL drain_%0d got dv=%b do=%h exp 1/%h",
                         i, dv0, dout0, W'(i));
            end
        end
        n_chk++;
        if (empty0 !== 1'b1) begin
            n_fail++;
            $display("FAIL drain_empty got %b exp 1", empty0);
        end
        step0(1'b0, 1'b1, 8'h00);
        n_chk++;
        if ({unf0, dv0} !== 2'b10 || got0() !== exp0()) begin
            n_fail++;
            $display("FAIL drain_unf got unf=%b dv=%b exp 1/0", unf0, dv0);
        end
        step0(1'b0, 1'b0, 8'h00);
        n_chk++;
        if (unf0 !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_unf_end got %b exp 0", unf0);
        end
    endtask

    task automatic test_simul();
        for (int i = 0; i < D; i++) step0(1'b1, 1'b0, W'(8'h80 + i));
        step0(1'b1, 1'b1, 8'h55);
        n_chk++;
        if ({cnt0, ovf0, dout0} !== {6'd32, 1'b0, 8'h80} ||
            got0() !== exp0()) begin
            n_fail++;
            $display("FAIL simul_full got cnt=%0d ovf=%b do=%h exp 32/0/80",
                     cnt0, ovf0, dout0);
        end
        for (int i = 0; i < D; i++) step0(1'b0, 1'b1, 8'h00);
        n_chk++;
        if ({dout0, empty0} !== {8'h55, 1'b1}) begin
            n_fail++;
            $display("FAIL simul_last got do=%h e=%b exp 55/1", dout0, empty0);
        end
        step0(1'b1, 1'b1, 8'h66);
        n_chk++;
        if ({unf0, cnt0} !== {1'b1, 6'd1} || got0() !== exp0()) begin
            n_fail++;
            $display("FAIL simul_empty got unf=%b cnt=%0d exp 1/1", unf0, cnt0);
        end
        step0(1'b0, 1'b1, 8'h00);
        n_chk++;
        if ({dout0, unf0, empty0} !== {8'h66, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL simul_pop got do=%h unf=%b e=%b exp 66/0/1",
                     dout0, unf0, empty0);
        end
    endtask

    task automatic test_wrap();
        logic [W-1:0] d = 8'h00;
        int bad = 0;
        for (int c = 0; c < 200; c++) begin
            int wp = (c % 80 < 40) ? 75 : 30;
            logic w = ($urandom_range(0, 99) < wp);
            logic r = ($urandom_range(0, 99) < 100 - wp);
            step0(w, r, d);
            d++;
            if (got0() !== exp0()) begin
                bad++;
                if (bad < 5)
                    $display("FAIL wrap_c%0d got %h exp %h", c, got0(), exp0());
            end
        end
        while (q0.size() != 0) begin
            step0(1'b0, 1'b1, 8'h00);
            if (got0() !== exp0()) begin
                bad++;
                if (bad < 5)
                    $display("FAIL wrap_drain got %h exp %h", got0(), exp0());
            end
        end
        n_chk++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL wrap_total got %0d bad cycles exp 0", bad);
        end
    endtask

    task automatic test_fwft_reset();
        step1(1'b1, 1'b0, 8'h11);
        n_chk++;
        if ({dout1, dv1} !== {8'h11, 1'b1} || got1() !== exp1()) begin
            n_fail++;
            $display("FAIL fwft_first got do=%h dv=%b exp 11/1", dout1, dv1);
        end
        step1(1'b1, 1'b0, 8'h22);
        n_chk++;
        if (dout1 !== 8'h11 || got1() !== exp1()) begin
            n_fail++;
            $display("FAIL fwft_hold got do=%h exp 11", dout1);
        end
        step1(1'b0, 1'b1, 8'h00);
        n_chk++;
        if ({dout1, cnt1} !== {8'h22, 6'd1} || got1() !== exp1()) begin
            n_fail++;
            $display("FAIL fwft_pop got do=%h cnt=%0d exp 22/1", dout1, cnt1);
        end
        for (int i = 0; i < 4; i++) step1(1'b1, 1'b0, W'(8'h30 + i));
        step0(1'b1, 1'b0, 8'h77);
        n_chk++;
        if (cnt1 !== 6'd5 || got1() !== exp1()) begin
            n_fail++;
            $display("FAIL fwft_cnt5 got %0d exp 5", cnt1);
        end
        #2;
        rst = 1'b0;
        #1;
        n_chk++;
        if ({cnt1, empty1, dv1} !== {6'd0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL async_rst1 got cnt=%0d e=%b dv=%b exp 0/1/0",
                     cnt1, empty1, dv1);
        end
        n_chk++;
        if ({cnt0, empty0, dv0} !== {6'd0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL async_rst0 got cnt=%0d e=%b dv=%b exp 0/1/0",
                     cnt0, empty0, dv0);
        end
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        step1(1'b0, 1'b0, 8'h00);
        n_chk++;
        if (got1() !== exp1()) begin
            n_fail++;
            $display("FAIL fwft_after_rst got %h exp %h", got1(), exp1());
        end
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        we0 = 1'b0; re0 = 1'b0; din0 = '0;
        we1 = 1'b0; re1 = 1'b0; din1 = '0;
        model_reset();
        test_reset();
        test_fill();
        test_drain();
        test_simul();
        test_wrap();
        test_fwft_reset();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got no finish exp finish");
        $fatal(1);
    end

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
Single-clock, fully parametrised FIFO that succeeds the fixed 32x8 FIFO. It adds programmable almost-full and almost-empty thresholds, an occupancy count, and overflow/underflow error pulses. A selectable output mode offers either a standard registered read or first-word-fall-through (FWFT). It is intended as the general buffering block between same-clock producer and consumer stages.

Parameters:
DEPTH, 32, number of entries; must be a power of 2, >=4
WIDTH, 8, data word width in bits
AF_THRESH, DEPTH-4, almost_full asserted when count >= AF_THRESH
AE_THRESH, 4, almost_empty asserted when count <= AE_THRESH
FWFT, 0, 0 = registered read (1-cycle latency); 1 = first-word-fall-through

Ports:
clk  input  1  single clock; all logic on rising edge
rst  input  1  asynchronous reset, active-low
data_in  input  WIDTH  write data
write_en  input  1  write request
read_en  input  1  read request
data_out  output  WIDTH  read data
data_valid  output  1  data_out holds a newly read word (FWFT=0); equals ~empty (FWFT=1)
full  output  1  count == DEPTH
empty  output  1  count == 0
almost_full  output  1  count >= AF_THRESH
almost_empty  output  1  count <= AE_THRESH
count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
overflow  output  1  one-cycle pulse: write rejected
underflow  output  1  one-cycle pulse: read rejected

Behaviour:
- Reset (rst=0, asynchronous, independent of clk):
  - wr_ptr=0, rd_ptr=0, count=0, data_out=0, data_valid=0.
  - empty=1, full=0, almost_empty=1, almost_full=0, overflow=0, underflow=0.
  - Memory contents are not cleared.
  - Reset asserted mid-operation discards all stored words immediately.
- Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Write acceptance: wr_acc = write_en & (~full | rd_acc).
  - A write into a full FIFO is accepted only if a read is accepted in the same cycle.
- Read acceptance: rd_acc = read_en & ~empty.
  - A read of an empty FIFO is rejected even if a write occurs in the same cycle.
- On wr_acc: mem[wr_ptr] <= data_in; wr_ptr increments.
- On rd_acc: rd_ptr increments.
- Count update: count_next = count + wr_acc - rd_acc.
  - Simultaneous accepted read and write leaves count unchanged.
- full, empty, almost_full and almost_empty are registered from count_next, so they are valid in the cycle after the edge that changed count.
- overflow <= write_en & ~wr_acc. underflow <= read_en & ~rd_acc. Both are single-cycle registered pulses with no side effects on the FIFO state.
- FWFT=0:
  - On rd_acc, data_out <= mem[rd_ptr] and data_valid <= 1. The word is visible one cycle after the read edge.
  - Otherwise data_valid <= 0 and data_out holds its last value.
- FWFT=1:
  - data_out = mem[rd_ptr] combinationally whenever empty=0; data_valid = ~empty.
  - read_en pops the displayed word, and the next word appears in the same cycle the pointer advances.
  - A word written into an empty FIFO appears on data_out one cycle after the write edge, when empty deasserts.
- Ordering: strictly first-in first-out; no word is lost, duplicated or reordered across pointer wrap-around.
- Threshold parameters outside 0..DEPTH are illegal; the block flags them with an elaboration-time $error.

Test Plan:
1. Reset/idle (DEPTH=32, WIDTH=8, defaults):
   - Stimulus: hold rst=0 for 3 cycles, release.
   - Required: count=0, empty=1, almost_empty=1, full=0, almost_full=0, data_out=0, data_valid=0, no error pulses.
2. Fill to full:
   - Stimulus: write 0x00..0x1F on consecutive cycles, then one more write of 0xAA.
   - Required: almost_empty falls after the 5th write; almost_full rises after the 28th; full=1 and count=32 after the 32nd.
   - Required: the 33rd write produces one overflow pulse and count stays 32.
3. Drain and underflow (FWFT=0):
   - Stimulus: read 32 times from the full FIFO of scenario 2.
   - Required: data_out is 0x00..0x1F in order, each with data_valid=1 one cycle after its read.
   - Required: empty=1 afterwards; a 33rd read gives one underflow pulse and data_valid=0.
4. Simultaneous read/write:
   - Stimulus: at count=32, assert write_en=1 (0x55) and read_en=1 together; then at count=0, assert both together.
   - Required: in the full case both are accepted, count stays 32, no overflow, and 0x55 emerges last.
   - Required: in the empty case the write is accepted, the read is rejected, underflow pulses once and count=1.
5. Wrap-around stress:
   - Stimulus: 200 cycles of random write_en/read_en with incrementing data.
   - Required: every accepted word is read out exactly once in order, count always matches the scoreboard, and no false flags occur across multiple pointer wraps.
6. FWFT=1 and reset mid-operation:
   - Stimulus: write 0x11 then 0x22.
   - Required: data_out=0x11 with data_valid=1 one cycle after the first write; read_en for one cycle makes data_out=0x22.
   - Stimulus: assert rst=0 asynchronously between clock edges at count=5.
   - Required: count=0, empty=1 and data_valid=0 immediately, without waiting for a clock edge.
